frontend_sweep_controller: RTL
==============================

Name: frontend_sweep_controller

Overview:
Sequences the ADC/DAC frontend through a programmed frequency sweep. For each point it:
- writes the DCO phase increment;
- waits a settle interval for the phase-increment and result filters to converge;
- averages 2^AVG_LOG2 samples of the filtered SIN/COS mul-acc outputs;
- hands the result to a downstream consumer over a valid/ready handshake.

It sits between the host/config register block and adc_dac_frontend (PHASE_INCREMENT_IN, SIN_MUL_ACC, COS_MUL_ACC).

Parameters:
PHASE_INCREMENT_BITS, 28, width of phase increment written to the DCO
RESULT_MUL_ACC_WIDTH, 38, width of signed SIN/COS inputs and of averaged outputs
SETTLE_BITS, 16, width of settle-cycle counter
STEP_COUNT_BITS, 8, width of sweep point count and point index
AVG_LOG2, 4, log2 of samples averaged per point

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
CE  in  1  clock enable; settle/accumulate counters advance only when CE=1
START  in  1  one-cycle start pulse, honoured only in IDLE
ABORT  in  1  return to IDLE at next edge from any state
START_INC  in  PHASE_INCREMENT_BITS  phase increment of point 0
STEP_INC  in  PHASE_INCREMENT_BITS  signed per-point increment delta
STEP_COUNT  in  STEP_COUNT_BITS  number of sweep points
SETTLE_CYCLES  in  SETTLE_BITS  CE cycles to wait after each increment write
SIN_MUL_ACC  in  RESULT_MUL_ACC_WIDTH  signed filtered SIN product from frontend
COS_MUL_ACC  in  RESULT_MUL_ACC_WIDTH  signed filtered COS product from frontend
PHASE_INCREMENT_OUT  out  PHASE_INCREMENT_BITS  to frontend PHASE_INCREMENT_IN
PHASE_INCREMENT_WE  out  1  one-cycle write strobe
RESULT_SIN  out  RESULT_MUL_ACC_WIDTH  averaged SIN
RESULT_COS  out  RESULT_MUL_ACC_WIDTH  averaged COS
RESULT_INDEX  out  STEP_COUNT_BITS  point index of current result
RESULT_VALID  out  1  result available
RESULT_READY  in  1  consumer accepts result
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse after last point accepted or on empty sweep

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state=IDLE;
  - all outputs 0, including PHASE_INCREMENT_OUT, BUSY and DONE;
  - accumulators and counters 0.
- States: IDLE, LOAD, SETTLE, ACCUM, OUTPUT, NEXT.
- IDLE:
  - START=1 with STEP_COUNT=0 → DONE pulses next cycle; stay IDLE; no WE.
  - START=1 with STEP_COUNT>0 → latch START_INC, STEP_INC, STEP_COUNT and SETTLE_CYCLES; index=0; go to LOAD.
- LOAD (one cycle, ignores CE):
  - PHASE_INCREMENT_OUT=current increment;
  - PHASE_INCREMENT_WE=1 for exactly this cycle;
  - load settle counter; go to SETTLE.
- SETTLE:
  - counter decrements on CE cycles;
  - leave when counter=0 and CE=1;
  - SETTLE_CYCLES=0 → exits on first CE cycle.
- ACCUM:
  - on each CE cycle add sign-extended SIN/COS into RESULT_MUL_ACC_WIDTH+AVG_LOG2 accumulators;
  - after 2^AVG_LOG2 samples go to OUTPUT.
- OUTPUT:
  - RESULT_SIN/COS = accumulator arithmetic right shift by AVG_LOG2 (floor toward −inf);
  - RESULT_VALID=1; RESULT_INDEX=index;
  - outputs stable while VALID=1 and READY=0;
  - on VALID&&READY go to NEXT.
- NEXT (one cycle):
  - VALID=0; clear accumulators;
  - index+1 = STEP_COUNT → DONE pulse, go to IDLE;
  - else increment += STEP_INC (modulo 2^PHASE_INCREMENT_BITS), index+1, go to LOAD.
- PHASE_INCREMENT_OUT holds its last value between writes and after DONE/ABORT.
- Backpressure: the sweep stalls in OUTPUT indefinitely; no further DCO writes occur.
- ABORT:
  - priority over START and all transitions;
  - next cycle: IDLE, VALID=0, BUSY=0, no DONE, no WE.
- START while BUSY: ignored.
- Registered config: START_INC, STEP_INC, STEP_COUNT and SETTLE_CYCLES may change during a sweep without effect.
- CE=0: freezes SETTLE/ACCUM progress only; LOAD, OUTPUT handshake and NEXT proceed regardless.
- Per-point latency with CE=1, READY=1: LOAD(1) + SETTLE(SETTLE_CYCLES+1) + ACCUM(2^AVG_LOG2) + OUTPUT(1) + NEXT(1) cycles.

Test Plan:
- Single point: START_INC=109377165, STEP_COUNT=1, SETTLE=10, SIN=1000, COS=−1000 constant, READY=1.
  - One WE with OUT=109377165.
  - VALID 29 cycles after START, with RESULT_SIN=1000, RESULT_COS=−1000, INDEX=0.
  - DONE one cycle after accept.
- Sweep with negative step: START_INC=10035786, STEP_INC=100000, STEP_COUNT=3.
  - WE values 10035786, 10135786, 10235786; INDEX 0,1,2; one DONE.
  - Repeat with STEP_INC=−100000 → 10035786, 9935786, 9835786.
- Averaging and wrap:
  - SIN alternating −3,0 across 16 samples → sum −24, RESULT_SIN=−2 (floor).
  - START_INC=2^28−1, STEP_INC=2 → second write is 1.
- Backpressure: READY=0 for 50 cycles at point 0.
  - VALID and results stable throughout; no WE during stall.
  - Resumes after READY=1.
- CE gating: CE=1 every 4th cycle, SETTLE=3 → SETTLE and ACCUM take 4× the cycles; results unchanged.
- ABORT and async reset:
  - ABORT in ACCUM → IDLE next cycle, BUSY=0, no DONE.
  - RESET_N low mid-SETTLE → all outputs 0 immediately, without a clock edge.
  - STEP_COUNT=0 START → DONE pulse, no WE.

Source files
------------

// File: rtl/frontend_sweep_controller.sv
// Walks the frontend DCO through a programmed list of phase increments. At each point it
// settles, averages 2^AVG_LOG2 SIN/COS samples and offers the result over valid/ready.

module frontend_sweep_controller #(
  parameter int PHASE_INCREMENT_BITS = 28,
  parameter int RESULT_MUL_ACC_WIDTH = 38,
  parameter int SETTLE_BITS          = 16,
  parameter int STEP_COUNT_BITS      = 8,
  parameter int AVG_LOG2             = 4
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            CE,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic [PHASE_INCREMENT_BITS-1:0] START_INC,
  input  logic [PHASE_INCREMENT_BITS-1:0] STEP_INC,
  input  logic [STEP_COUNT_BITS-1:0]      STEP_COUNT,
  input  logic [SETTLE_BITS-1:0]          SETTLE_CYCLES,
  input  logic [RESULT_MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
  input  logic [RESULT_MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
  output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
  output logic                            PHASE_INCREMENT_WE,
  output logic [RESULT_MUL_ACC_WIDTH-1:0] RESULT_SIN,
  output logic [RESULT_MUL_ACC_WIDTH-1:0] RESULT_COS,
  output logic [STEP_COUNT_BITS-1:0]      RESULT_INDEX,
  output logic                            RESULT_VALID,
  input  logic                            RESULT_READY,
  output logic                            BUSY,
  output logic                            DONE
);

  localparam int ACC_W        = RESULT_MUL_ACC_WIDTH + AVG_LOG2;
  localparam int SAMPLE_CNT_W = AVG_LOG2 + 1;
  localparam int SAMPLES      = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_ACCUM,
    S_OUTPUT,
    S_NEXT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [PHASE_INCREMENT_BITS-1:0] r_phaseOut;
  logic [PHASE_INCREMENT_BITS-1:0] r_stepInc;
  logic [STEP_COUNT_BITS-1:0]      r_stepCount;
  logic [SETTLE_BITS-1:0]          r_settleCfg;
  logic [STEP_COUNT_BITS-1:0]      r_index;
  logic [SETTLE_BITS-1:0]          r_settleCnt;
  logic [SAMPLE_CNT_W-1:0]         r_sampleCnt;
  logic [ACC_W-1:0]                r_accSin;
  logic [ACC_W-1:0]                r_accCos;
  logic                            r_done;

  logic             w_lastPoint;
  logic             w_sampleDone;
  logic [ACC_W-1:0] w_sinExt;
  logic [ACC_W-1:0] w_cosExt;

  assign w_lastPoint  = (r_index == r_stepCount - STEP_COUNT_BITS'(1));
  assign w_sampleDone = (r_sampleCnt == SAMPLE_CNT_W'(SAMPLES - 1));
  assign w_sinExt     = {{AVG_LOG2{SIN_MUL_ACC[RESULT_MUL_ACC_WIDTH-1]}}, SIN_MUL_ACC};
  assign w_cosExt     = {{AVG_LOG2{COS_MUL_ACC[RESULT_MUL_ACC_WIDTH-1]}}, COS_MUL_ACC};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (ABORT) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (START && STEP_COUNT != '0) w_nextState = S_LOAD;
        S_LOAD:   w_nextState = S_SETTLE;
        S_SETTLE: if (CE && r_settleCnt == '0) w_nextState = S_ACCUM;
        S_ACCUM:  if (CE && w_sampleDone) w_nextState = S_OUTPUT;
        S_OUTPUT: if (RESULT_READY) w_nextState = S_NEXT;
        S_NEXT:   w_nextState = w_lastPoint ? S_IDLE : S_LOAD;
        default:  w_nextState = S_IDLE;
      endcase
    end
  end

  always_comb begin
    PHASE_INCREMENT_WE = 1'b0;
    RESULT_VALID       = 1'b0;
    BUSY               = 1'b1;
    case (r_state)
      S_IDLE:   BUSY = 1'b0;
      S_LOAD:   PHASE_INCREMENT_WE = 1'b1;
      S_OUTPUT: RESULT_VALID = 1'b1;
      default:  ;
    endcase
  end

  // ABORT suppresses every datapath update, so an aborted sweep leaves the DCO value and DONE untouched.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_phaseOut  <= '0;
      r_stepInc   <= '0;
      r_stepCount <= '0;
      r_settleCfg <= '0;
      r_index     <= '0;
      r_settleCnt <= '0;
      r_sampleCnt <= '0;
      r_accSin    <= '0;
      r_accCos    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!ABORT) begin
        case (r_state)
          S_IDLE: begin
            if (START) begin
              if (STEP_COUNT == '0) begin
                r_done <= 1'b1;
              end else begin
                r_phaseOut  <= START_INC;
                r_stepInc   <= STEP_INC;
                r_stepCount <= STEP_COUNT;
                r_settleCfg <= SETTLE_CYCLES;
                r_index     <= '0;
              end
            end
          end
          S_LOAD: begin
            r_settleCnt <= r_settleCfg;
            r_sampleCnt <= '0;
            r_accSin    <= '0;
            r_accCos    <= '0;
          end
          S_SETTLE: begin
            if (CE && r_settleCnt != '0) r_settleCnt <= r_settleCnt - SETTLE_BITS'(1);
          end
          S_ACCUM: begin
            if (CE) begin
              r_accSin    <= r_accSin + w_sinExt;
              r_accCos    <= r_accCos + w_cosExt;
              r_sampleCnt <= r_sampleCnt + SAMPLE_CNT_W'(1);
            end
          end
          S_OUTPUT: begin
            if (RESULT_READY && w_lastPoint) r_done <= 1'b1;
          end
          S_NEXT: begin
            r_accSin <= '0;
            r_accCos <= '0;
            if (!w_lastPoint) begin
              r_phaseOut <= r_phaseOut + r_stepInc;
              r_index    <= r_index + STEP_COUNT_BITS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Dropping the low AVG_LOG2 bits of the two's-complement sum is the floor-toward-minus-infinity average.
  assign RESULT_SIN          = r_accSin[ACC_W-1:AVG_LOG2];
  assign RESULT_COS          = r_accCos[ACC_W-1:AVG_LOG2];
  assign RESULT_INDEX        = r_index;
  assign PHASE_INCREMENT_OUT = r_phaseOut;
  assign DONE                = r_done;

endmodule
